// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bundle between the multicycle sequencer and the MIPS datapath
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemToRead;
    logic             MemToWrite;
    logic             MemToReg;
    logic             IRWrite;
    logic             regDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic [3:0]       state;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_retired;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemToRead, MemToWrite, MemToReg,
               IRWrite, regDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               state, illegal_op, instr_retired
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemToRead, MemToWrite, MemToReg,
               IRWrite, regDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               state, illegal_op, instr_retired
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS sequencer with memory stall and retired-instruction counter
// Optional feature macro: MC_JUMP_EN (enables the j instruction / JUMP state).
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JUMP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           st;
    state_t           dispatch;
    logic             legal;
    logic [CNT_W-1:0] retired;

    always_comb begin
        legal    = 1'b1;
        dispatch = S_FETCH;
        case (bus.opcode)
            OP_RTYPE:      dispatch = S_R_EXEC;
            OP_LW, OP_SW:  dispatch = S_MEM_ADDR;
            OP_BEQ:        dispatch = S_BRANCH;
            OP_ADDI:       dispatch = S_ADDI_EXEC;
`ifdef MC_JUMP_EN
            OP_J:          dispatch = S_JUMP;
`endif
            default:       legal    = 1'b0;
        endcase
    end

    // Retirement is counted on the edge that returns to FETCH after a completed instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= S_IDLE;
            retired <= '0;
        end else begin
            case (st)
                S_IDLE:      st <= S_FETCH;
                S_FETCH:     if (bus.mem_ready) st <= S_DECODE;
                S_DECODE:    st <= dispatch;
                S_MEM_ADDR:  st <= (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:    if (bus.mem_ready) st <= S_MEM_WB;
                S_MEM_WR: begin
                    if (bus.mem_ready) begin
                        st      <= S_FETCH;
                        retired <= retired + 1'b1;
                    end
                end
                S_R_EXEC:    st <= S_R_WB;
                S_ADDI_EXEC: st <= S_ADDI_WB;
`ifdef MC_JUMP_EN
                S_JUMP,
`endif
                S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH: begin
                    st      <= S_FETCH;
                    retired <= retired + 1'b1;
                end
                default:     st <= S_FETCH;
            endcase
        end
    end

    assign bus.state         = st;
    assign bus.instr_retired = retired;

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemToRead   = 1'b0;
        bus.MemToWrite  = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.regDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.illegal_op  = 1'b0;
        case (st)
            S_FETCH: begin
                bus.MemToRead = 1'b1;
                bus.ALUSrcB   = 2'b01;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUSrcB    = 2'b11;
                bus.illegal_op = ~legal;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                bus.MemToRead = 1'b1;
                bus.IorD      = 1'b1;
            end
            S_MEM_WR: begin
                bus.MemToWrite = 1'b1;
                bus.IorD       = 1'b1;
            end
            S_MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = 1'b1;
            end
            S_R_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
            end
            S_R_WB: begin
                bus.RegWrite = 1'b1;
                bus.regDst   = 1'b1;
            end
            S_ADDI_WB:   bus.RegWrite = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the MIPS datapath: replaces single-cycle opcode decoding with a Moore/Mealy FSM that steps each instruction through fetch, decode, execute, memory and write-back. It drives the multiplexer selects, write enables and `ALUOp` for the shared ALU, register file, instruction register and unified memory. It stalls on a memory-ready handshake and keeps a retired-instruction counter.

## Interface
- `CNT_W`, 16, width of the retired-instruction counter.

Ports (clock and reset first):
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `opcode`  in  6  instruction bits [31:26] from the instruction register.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemToRead`, `MemToWrite`, `MemToReg`, `IRWrite`, `regDst`, `RegWrite`, `ALUSrcA`  out  1 each  datapath enables and selects.
- `ALUSrcB`  out  2  00 = B reg, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp`  out  2  00 = add, 01 = subtract (beq), 10 = funct field.
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state`  out  4  current state, for debug.
- `illegal_op`  out  1  high in DECODE when the opcode is unsupported.
- `instr_retired`  out  CNT_W  count of completed instructions.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, ADDI_EXEC=10, ADDI_WB=11, JUMP=12. Codes 13–15 go to FETCH with all outputs 0.
- Any output not listed for a state is 0.

State outputs:
- IDLE: all outputs 0.
- FETCH: `MemToRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00. `IRWrite` and `PCWrite` equal `mem_ready`.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00.
- MEM_ADDR and ADDI_EXEC: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00.
- MEM_RD: `MemToRead`=1, `IorD`=1.
- MEM_WR: `MemToWrite`=1, `IorD`=1.
- MEM_WB: `RegWrite`=1, `MemToReg`=1, `regDst`=0.
- R_EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10.
- R_WB: `RegWrite`=1, `regDst`=1, `MemToReg`=0.
- ADDI_WB: `RegWrite`=1, `regDst`=0, `MemToReg`=0.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01.
- JUMP: `PCWrite`=1, `PCSource`=10.

Transitions:
- IDLE → FETCH unconditionally.
- FETCH → DECODE when `mem_ready`=1; otherwise stay in FETCH.
- DECODE dispatches on `opcode`:
  - 000000 → R_EXEC
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDI_EXEC
  - 000010 (j) → JUMP
  - anything else → FETCH, with `illegal_op`=1
- MEM_ADDR → MEM_RD for lw, MEM_WR for sw. The opcode is re-sampled here; the IR is stable after FETCH.
- MEM_RD → MEM_WB when `mem_ready`=1.
- MEM_WR → FETCH when `mem_ready`=1.
- R_EXEC → R_WB; ADDI_EXEC → ADDI_WB.
- MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP → FETCH.

Retired-instruction counter:
- `instr_retired` increments by 1 on every transition into FETCH from MEM_WB, MEM_WR, R_WB, ADDI_WB, BRANCH or JUMP.
- It does not increment on the illegal-opcode path or on IDLE → FETCH.
- It wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values:
  - `state`=IDLE and `instr_retired`=0.
  - Every other output is 0, because all outputs decode from IDLE.
- Reset asserted mid-instruction forces IDLE immediately and asynchronously. Any in-flight memory access is abandoned, with no further write enables.
- Outputs are combinational from `state`. Only FETCH `PCWrite` and `IRWrite` also depend on `mem_ready`.
- Latency with `mem_ready` held at 1 (the first instruction after reset adds 1 IDLE cycle):
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Each cycle `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds 1 cycle with outputs held steady.
- `mem_ready` is ignored in every other state.

## Configuration
- `MC_JUMP_EN` defined: opcode 000010 dispatches to JUMP as described above.
- `MC_JUMP_EN` undefined:
  - The JUMP state is not compiled in.
  - `PCSource` never equals 10.
  - Opcode 000010 is treated as illegal: DECODE → FETCH with `illegal_op`=1 and no counter increment.

## Test plan
- Reset released, `mem_ready`=1, opcode 000000 → states 0,1,2,7,8,1. `RegWrite`=1 and `regDst`=1 in state 8. `instr_retired`=1.
- opcode 100011 with `mem_ready` low for 2 cycles in MEM_RD → 7 cycles from FETCH to the next FETCH. `MemToRead`=`IorD`=1 throughout the stall. `MemToReg`=1 in MEM_WB.
- opcode 000100 → BRANCH has `PCWriteCond`=1, `ALUOp`=01, `PCSource`=01. Back in FETCH 3 cycles after entering FETCH.
- opcode 111111 → `illegal_op`=1 for 1 cycle in DECODE, then FETCH; `instr_retired` unchanged.
- `rst` pulsed while in MEM_WR → `state`=0 and `MemToWrite`=0 within the same cycle; `instr_retired`=0.
- `CNT_W`=2, 5 R-type instructions → `instr_retired` reads 1,2,3,0,1; with `MC_JUMP_EN` undefined, opcode 000010 raises `illegal_op`.
